branch_cond_unit: RTL and testbench

Registered, parametrised branch-condition unit for the CPU's jump path. It replaces the purely combinational compare with several additions:
- a one-stage pipelined evaluator behind a valid/ready handshake;
- signed as well as unsigned compares;
- a stored ALU flag register (Z/N/C/V) with same-cycle bypass;
- a hardware loop counter for decrement-and-jump.

It sits between decode/register-read and PC-select logic.

---
 rtl/branch_cond_unit_if.sv | 46 ++++
 rtl/branch_cond_unit.sv | 129 ++++++++++++
 tb/tb_branch_cond_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_unit_if.sv
// Bus bundle for branch_cond_unit: request/result handshake, operands,
// ALU flag write port, loop-counter load port and the architectural state
// (flags, loop_count) observed by the CPU.
//   master : decode/ALU/PC-select side (drives requests, consumes results)
//   slave  : branch_cond_unit
interface branch_cond_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned COND_W = 5
);
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic [COND_W-1:0] cond;
  logic [WIDTH-1:0]  rddata;
  logic [WIDTH-1:0]  rsdata;
  logic [WIDTH-1:0]  imm;
  // ALU flag write port
  logic              alu_valid;
  logic              alu_flags_we;
  logic [WIDTH-1:0]  aluout;
  logic              alu_carry;
  logic              alu_ovf;
  // loop counter load port
  logic              lc_load;
  logic [WIDTH-1:0]  lc_value;
  // result channel and visible state
  logic              res_valid;
  logic              res_ready;
  logic              jump;
  logic [3:0]        flags;
  logic [WIDTH-1:0]  loop_count;

  modport master (
    output req_valid, cond, rddata, rsdata, imm,
    output alu_valid, alu_flags_we, aluout, alu_carry, alu_ovf,
    output lc_load, lc_value, res_ready,
    input  req_ready, res_valid, jump, flags, loop_count
  );

  modport slave (
    input  req_valid, cond, rddata, rsdata, imm,
    input  alu_valid, alu_flags_we, aluout, alu_carry, alu_ovf,
    input  lc_load, lc_value, res_ready,
    output req_ready, res_valid, jump, flags, loop_count
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Registered branch-condition unit for the jump path.
// One-stage evaluator behind a valid/ready handshake; evaluates register,
// immediate, flag and loop-counter conditions and returns a registered jump.
// Ports:
//   clk      : clock, all state on rising edge
//   reset_n  : synchronous active-low reset
//   bus      : branch_cond_unit_if.slave (handshake, operands, flag/loop ports)
module branch_cond_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned COND_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  branch_cond_unit_if.slave    bus
);

  localparam int unsigned FLAG_W = 4;
  localparam logic [4:0]  C_DJNZ = 5'b10110;

  logic                     res_valid_q, res_valid_d;
  logic                     jump_q, jump_d;
  logic [FLAG_W-1:0]        flags_q, flags_d;
  logic [WIDTH-1:0]         loop_count_q, loop_count_d;

  logic                     accept;
  logic                     flag_upd;
  logic                     cond_hi_zero;
  logic                     is_djnz;
  logic                     eval_jump;
  logic [4:0]               cond_lo;
  logic [FLAG_W-1:0]        flags_eff;
  logic [WIDTH-1:0]         lc_cur;
  logic [WIDTH-1:0]         lc_dec;
  logic signed [WIDTH-1:0]  rd_s, rs_s, imm_s;

  // Handshake: a held result blocks new requests unless it drains this cycle.
  assign bus.req_ready = !res_valid_q || bus.res_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // Effective flags/count: same-cycle writes bypass into the evaluator.
  assign flag_upd  = bus.alu_valid && bus.alu_flags_we;
  assign flags_eff = flag_upd ? {(bus.aluout == '0), bus.aluout[WIDTH-1],
                                 bus.alu_carry, bus.alu_ovf}
                              : flags_q;
  assign lc_cur    = bus.lc_load ? bus.lc_value : loop_count_q;
  assign lc_dec    = lc_cur - WIDTH'(1);

  // Codes with any bit set above bit 4 are "never".
  assign cond_hi_zero = ((bus.cond >> 5) == '0);
  assign cond_lo      = bus.cond[4:0];
  assign is_djnz      = cond_hi_zero && (cond_lo == C_DJNZ);

  assign rd_s  = $signed(bus.rddata);
  assign rs_s  = $signed(bus.rsdata);
  assign imm_s = $signed(bus.imm);

  // Condition evaluation; flags are {Z,N,C,V} = bits [3:0].
  always_comb begin
    eval_jump = 1'b0;
    if (cond_hi_zero) begin
      case (cond_lo)
        5'b00000: eval_jump = (bus.rddata == bus.rsdata);
        5'b00001: eval_jump = (bus.rddata != bus.rsdata);
        5'b00010: eval_jump = (bus.rddata >  bus.rsdata);
        5'b00011: eval_jump = (bus.rddata <  bus.rsdata);
        5'b00100: eval_jump = (bus.rddata == '0);
        5'b00101: eval_jump = bus.rddata[WIDTH-1];
        5'b00110: eval_jump = (bus.rddata == '1);
        5'b00111: eval_jump = (rd_s > rs_s);
        5'b01000: eval_jump = (bus.rddata == bus.imm);
        5'b01001: eval_jump = (bus.rddata != bus.imm);
        5'b01010: eval_jump = (bus.rddata >  bus.imm);
        5'b01011: eval_jump = (bus.rddata <  bus.imm);
        5'b01100: eval_jump = (rd_s > imm_s);
        5'b01101: eval_jump = (rd_s < imm_s);
        5'b01110: eval_jump = (rd_s < rs_s);
        5'b01111: eval_jump = 1'b1;
        5'b10000: eval_jump = flags_eff[3];
        5'b10001: eval_jump = !flags_eff[3];
        5'b10010: eval_jump = flags_eff[2];
        5'b10011: eval_jump = flags_eff[1];
        5'b10100: eval_jump = flags_eff[0];
        5'b10101: eval_jump = flags_eff[2] ^ flags_eff[0];
        5'b10110: eval_jump = (lc_dec != '0);
        5'b10111: eval_jump = (lc_cur == '0);
        default:  eval_jump = 1'b0;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    res_valid_d  = res_valid_q;
    jump_d       = jump_q;
    flags_d      = flags_eff;
    loop_count_d = lc_cur;
    if (accept) begin
      res_valid_d = 1'b1;
      jump_d      = eval_jump;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
    // Only an accepted DJNZ decrements; a stalled one leaves the count alone.
    if (accept && is_djnz) begin
      loop_count_d = lc_dec;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_valid_q  <= 1'b0;
      jump_q       <= 1'b0;
      flags_q      <= '0;
      loop_count_q <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      jump_q       <= jump_d;
      flags_q      <= flags_d;
      loop_count_q <= loop_count_d;
    end
  end

  assign bus.res_valid  = res_valid_q;
  assign bus.jump       = jump_q;
  assign bus.flags      = flags_q;
  assign bus.loop_count = loop_count_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_cond_unit;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_cond_unit_if #(.WIDTH(W), .COND_W(5)) bif ();

  branch_cond_unit #(.WIDTH(W), .COND_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit          m_rv   = 1'b0;
  bit          m_jump = 1'b0;
  logic [3:0]  m_flags = 4'h0;
  logic [15:0] m_lc = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sv(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  // Branch decision straight from the condition table.
  function automatic bit model_eval(input logic [4:0] c, input logic [15:0] rd,
                                    input logic [15:0] rs, input logic [15:0] n,
                                    input logic [3:0] f, input logic [15:0] lc);
    bit z, ng, cy, v;
    {z, ng, cy, v} = f;
    case (int'(c))
      0:  return rd == rs;
      1:  return rd != rs;
      2:  return int'(rd) > int'(rs);
      3:  return int'(rd) < int'(rs);
      4:  return rd == 16'h0000;
      5:  return sv(rd) < 0;
      6:  return rd == 16'hFFFF;
      7:  return sv(rd) > sv(rs);
      8:  return rd == n;
      9:  return rd != n;
      10: return int'(rd) > int'(n);
      11: return int'(rd) < int'(n);
      12: return sv(rd) > sv(n);
      13: return sv(rd) < sv(n);
      14: return sv(rd) < sv(rs);
      15: return 1'b1;
      16: return z;
      17: return !z;
      18: return ng;
      19: return cy;
      20: return v;
      21: return ng != v;
      22: return lc != 16'd1;
      23: return lc == 16'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    reset_n          = 1'b1;
    bif.req_valid    = 1'b0;
    bif.cond         = 5'd0;
    bif.rddata       = 16'h0;
    bif.rsdata       = 16'h0;
    bif.imm          = 16'h0;
    bif.alu_valid    = 1'b0;
    bif.alu_flags_we = 1'b0;
    bif.aluout       = 16'h0;
    bif.alu_carry    = 1'b0;
    bif.alu_ovf      = 1'b0;
    bif.lc_load      = 1'b0;
    bif.lc_value     = 16'h0;
    bif.res_ready    = 1'b1;
  endtask

  // Compare process for one cycle: inputs are already applied away from the edge.
  task automatic step();
    bit rdy, acc;
    logic [3:0]  nf;
    logic [15:0] lcc;
    #1;
    rdy = !m_rv || bif.res_ready;
    chk("req_ready", 32'(bif.req_ready), 32'(rdy));
    if (!reset_n) begin
      m_rv = 1'b0; m_jump = 1'b0; m_flags = 4'h0; m_lc = 16'h0;
    end else begin
      acc = bif.req_valid && rdy;
      nf  = (bif.alu_valid && bif.alu_flags_we)
            ? {bif.aluout == 16'h0, bif.aluout[15], bif.alu_carry, bif.alu_ovf} : m_flags;
      lcc = bif.lc_load ? bif.lc_value : m_lc;
      m_lc = lcc;
      if (acc) begin
        m_jump = model_eval(bif.cond, bif.rddata, bif.rsdata, bif.imm, nf, lcc);
        if (bif.cond == 5'd22) m_lc = lcc - 16'd1;
        m_rv = 1'b1;
      end else begin
        m_rv = m_rv && !bif.res_ready;
      end
      m_flags = nf;
    end
    @(posedge clk);
    #1;
    chk("res_valid", 32'(bif.res_valid), 32'(m_rv));
    chk("flags", 32'(bif.flags), 32'(m_flags));
    chk("loop_count", 32'(bif.loop_count), 32'(m_lc));
    if (m_rv) chk("jump", 32'(bif.jump), 32'(m_jump));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  bit          exp_j[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] exp_lc[4] = '{16'd2, 16'd1, 16'd0, 16'hFFFF};

  initial begin
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    step();
    chk("rst_res_valid", 32'(bif.res_valid), 32'd0);
    chk("rst_jump", 32'(bif.jump), 32'd0);
    chk("rst_flags", 32'(bif.flags), 32'd0);
    chk("rst_lc", 32'(bif.loop_count), 32'd0);

    // Signed vs unsigned greater-than
    idle(); bif.req_valid = 1'b1; bif.cond = 5'b00111;
    bif.rddata = 16'h8000; bif.rsdata = 16'h0001;
    step();
    chk("sgt_valid", 32'(bif.res_valid), 32'd1);
    chk("sgt_jump", 32'(bif.jump), 32'd0);
    bif.cond = 5'b00010;
    step();
    chk("ugt_jump", 32'(bif.jump), 32'd1);

    // Flag bypass
    idle(); bif.alu_valid = 1'b1; bif.alu_flags_we = 1'b1;
    bif.aluout = 16'h0000; bif.alu_carry = 1'b1;
    bif.req_valid = 1'b1; bif.cond = 5'b10000;
    step();
    chk("bypass_jump", 32'(bif.jump), 32'd1);
    chk("bypass_flags", 32'(bif.flags), 32'hA);

    // DJNZ sequence
    idle(); bif.lc_load = 1'b1; bif.lc_value = 16'd3;
    step();
    chk("lc_loaded", 32'(bif.loop_count), 32'd3);
    for (int i = 0; i < 4; i++) begin
      idle(); bif.req_valid = 1'b1; bif.cond = 5'b10110;
      step();
      chk("djnz_jump", 32'(bif.jump), 32'(exp_j[i]));
      chk("djnz_lc", 32'(bif.loop_count), 32'(exp_lc[i]));
    end

    // Backpressure with a DJNZ waiting
    idle(); bif.res_ready = 1'b0; bif.req_valid = 1'b1; bif.cond = 5'b10110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_req_ready", 32'(bif.req_ready), 32'd0);
      chk("bp_jump", 32'(bif.jump), 32'd1);
      chk("bp_lc", 32'(bif.loop_count), 32'hFFFF);
    end
    bif.res_ready = 1'b1;
    step();
    chk("bp_release_lc", 32'(bif.loop_count), 32'hFFFE);
    idle();
    step();
    chk("bp_once_lc", 32'(bif.loop_count), 32'hFFFE);
    chk("bp_drained", 32'(bif.res_valid), 32'd0);

    // Load and DJNZ in the same cycle
    idle(); bif.lc_load = 1'b1; bif.lc_value = 16'd1;
    bif.req_valid = 1'b1; bif.cond = 5'b10110;
    step();
    chk("ld_djnz_lc", 32'(bif.loop_count), 32'd0);
    chk("ld_djnz_jump", 32'(bif.jump), 32'd0);

    // Reset mid-operation
    idle(); bif.lc_load = 1'b1; bif.lc_value = 16'd5;
    step();
    idle(); bif.res_ready = 1'b0; bif.req_valid = 1'b1; bif.cond = 5'b01111;
    step();
    chk("pre_rst_valid", 32'(bif.res_valid), 32'd1);
    chk("pre_rst_lc", 32'(bif.loop_count), 32'd5);
    reset_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(bif.res_valid), 32'd0);
    chk("mid_rst_lc", 32'(bif.loop_count), 32'd0);
    chk("mid_rst_flags", 32'(bif.flags), 32'd0);
    idle();
    chk("post_rst_ready", 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1; bif.cond = 5'b11010;
    bif.rddata = 16'h1234; bif.rsdata = 16'h1234;
    step();
    chk("never_valid", 32'(bif.res_valid), 32'd1);
    chk("never_jump", 32'(bif.jump), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset_n          = ($urandom_range(0, 63) != 0);
      bif.req_valid    = ($urandom_range(0, 3) != 0);
      bif.cond         = 5'($urandom_range(0, 31));
      bif.rddata       = pick();
      bif.rsdata       = ($urandom_range(0, 3) == 0) ? bif.rddata : pick();
      bif.imm          = ($urandom_range(0, 3) == 0) ? bif.rddata : pick();
      bif.alu_valid    = ($urandom_range(0, 1) != 0);
      bif.alu_flags_we = ($urandom_range(0, 1) != 0);
      bif.aluout       = pick();
      bif.alu_carry    = 1'($urandom_range(0, 1));
      bif.alu_ovf      = 1'($urandom_range(0, 1));
      bif.lc_load      = ($urandom_range(0, 7) == 0);
      bif.lc_value     = 16'($urandom_range(0, 4));
      bif.res_ready    = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
